// File: rtl/lv_abist_seq.sv
// lv_abist_seq - multi-channel analog BIST sequencer for the LV domain.
//
// Walks CH_NUM analog detectors one at a time. For each channel it checks that
// the detector is low, then forces the stimulus and waits for the detector to
// fire within WIN_CYC cycles. It then removes the stimulus and waits GAP_CYC
// cycles, and finally checks that the detector has released. When all channels
// are done it reports the result and enables logic BIST.
//
// Optional build macro: ABIST_DGL_EN. When it is defined, a detect during the
// stimulus window qualifies only after DGL_CYC consecutive high cycles. When it
// is undefined, a single high cycle qualifies and no deglitch logic exists.
//
// Ports:
//   i_clk         block clock
//   i_rst_n       asynchronous active-low reset
//   i_bist_en     level enable; low aborts to idle
//   i_ch_mask     1 = skip channel (reported as pass)
//   i_det         detector flags, already synchronised to i_clk
//   o_stim        one-hot stimulus force
//   o_ch_rult     per-channel result, 1 = pass
//   o_abist_rult  AND of o_ch_rult, qualified by done
//   o_abist_done  sequence complete
//   o_lbist_en    logic-BIST enable
module lv_abist_seq #(
    parameter int unsigned CLK_M   = 48,
    parameter int unsigned CH_NUM  = 4,
    parameter int unsigned WIN_US  = 70,
    parameter int unsigned GAP_US  = 2,
    parameter int unsigned DGL_CYC = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bist_en,
    input  logic [CH_NUM-1:0] i_ch_mask,
    input  logic [CH_NUM-1:0] i_det,
    output logic [CH_NUM-1:0] o_stim,
    output logic [CH_NUM-1:0] o_ch_rult,
    output logic              o_abist_rult,
    output logic              o_abist_done,
    output logic              o_lbist_en
);

    localparam int unsigned WIN_CYC = WIN_US * CLK_M;
    localparam int unsigned GAP_CYC = GAP_US * CLK_M;
    localparam int unsigned CNT_MAX = (WIN_CYC > GAP_CYC) ? WIN_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    typedef enum logic [2:0] {StIdle, StSel, StStim, StGap, StDone} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pass_q, pass_d;
    logic [CH_NUM-1:0] stim_q, stim_d;
    logic [CH_NUM-1:0] rult_q, rult_d;
    logic              done_q, done_d;
    logic              lbist_q, lbist_d;
    logic              all_q, all_d;

    logic              det_cur;
    logic              det_qual;
    logic [CNT_W-1:0]  cnt_inc;
    logic              advance;

    assign det_cur = i_det[idx_q];
    // Saturating increment; the counter never wraps.
    assign cnt_inc = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef ABIST_DGL_EN
    localparam int unsigned DGL_W = $clog2(DGL_CYC + 1);

    logic [DGL_W-1:0] run_q, run_d;

    // Length of the current high run of the selected detector during STIM.
    always_comb begin
        run_d = '0;
        if (i_bist_en && state_q == StStim && det_cur) begin
            run_d = (run_q == DGL_W'(DGL_CYC)) ? run_q : run_q + DGL_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Qualifies on the DGL_CYC-th consecutive high cycle.
    assign det_qual = det_cur && (run_q >= DGL_W'(DGL_CYC - 1));
`else
    assign det_qual = det_cur;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        rult_d  = rult_q;
        advance = 1'b0;

        if (!i_bist_en) begin
            // Abort: results are kept for inspection until the next run.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    rult_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = StSel;
                end
                StSel: begin
                    if (i_ch_mask[idx_q]) begin
                        rult_d[idx_q] = 1'b1;
                        advance       = 1'b1;
                    end else if (det_cur) begin
                        // Stuck high before any stimulus: leave result at fail.
                        advance = 1'b1;
                    end else begin
                        cnt_d   = '0;
                        pass_d  = 1'b0;
                        state_d = StStim;
                    end
                end
                StStim: begin
                    cnt_d = cnt_inc;
                    if (det_qual) begin
                        pass_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StGap;
                    end else if (cnt_q == CNT_W'(WIN_CYC - 1)) begin
                        cnt_d   = '0;
                        state_d = StGap;
                    end
                end
                StGap: begin
                    cnt_d = cnt_inc;
                    if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        // A detector still high after the gap is stuck.
                        rult_d[idx_q] = pass_q & ~det_cur;
                        advance       = 1'b1;
                    end
                end
                StDone: begin
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (advance) begin
                cnt_d = '0;
                if (idx_q == IDX_W'(CH_NUM - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = StSel;
                end
            end
        end

        // Outputs are registered decodes of the next state.
        stim_d = '0;
        if (state_d == StStim) begin
            stim_d[idx_d] = 1'b1;
        end
        done_d  = (state_d == StDone);
        lbist_d = (state_d == StDone);
        all_d   = (state_d == StDone) && (&rult_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            stim_q  <= '0;
            rult_q  <= '0;
            done_q  <= 1'b0;
            lbist_q <= 1'b0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            stim_q  <= stim_d;
            rult_q  <= rult_d;
            done_q  <= done_d;
            lbist_q <= lbist_d;
            all_q   <= all_d;
        end
    end

    assign o_stim       = stim_q;
    assign o_ch_rult    = rult_q;
    assign o_abist_rult = all_q;
    assign o_abist_done = done_q;
    assign o_lbist_en   = lbist_q;

endmodule

// File: doc/lv_abist_seq.md
Name: lv_abist_seq

Overview:
- Parametrised multi-channel analog BIST sequencer for the LV domain.
- Walks CH_NUM analog detectors (OV/UV/OT comparators) one at a time. For each channel it forces a stimulus, checks that the detector fires inside a time window, then checks that it releases after the stimulus is removed.
- Reports per-channel and overall pass/fail, then hands off to logic BIST via o_lbist_en.
- Sits between the top-level BIST controller and the LV analog trim/force interface.

Parameters:
- CLK_M, 48, clock cycles per microsecond.
- CH_NUM, 4, number of analog channels under test (1..16).
- WIN_US, 70, detection window per channel in us; WIN_CYC = WIN_US*CLK_M.
- GAP_US, 2, release/recovery time after stimulus removal in us; GAP_CYC = GAP_US*CLK_M.
- DGL_CYC, 3, deglitch length in cycles; used only with ABIST_DGL_EN.

Ports:
- i_clk  input  1  block clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_bist_en  input  1  level enable from the BIST controller; low aborts and returns to IDLE.
- i_ch_mask  input  CH_NUM  1 = skip channel; the channel is reported as pass.
- i_det  input  CH_NUM  detector flags, already synchronised to i_clk.
- o_stim  output  CH_NUM  one-hot stimulus force to the analog block.
- o_ch_rult  output  CH_NUM  per-channel result, 1 = pass.
- o_abist_rult  output  1  AND of o_ch_rult, qualified by done.
- o_abist_done  output  1  sequence complete.
- o_lbist_en  output  1  logic-BIST enable.

Behaviour:
- Reset values: o_stim=0, o_ch_rult=0, o_abist_rult=0, o_abist_done=0, o_lbist_en=0, FSM=IDLE, ch_idx=0, cnt=0.
- All outputs are registered.
- Counter width is $clog2(max(WIN_CYC,GAP_CYC)+1); the counter saturates and never wraps.
- FSM states: IDLE, SEL, STIM, GAP, DONE.
- IDLE:
  - On i_bist_en=1: clear o_ch_rult to 0, set ch_idx=0, go to SEL.
- SEL (1 cycle):
  - If i_ch_mask[ch_idx]=1: set o_ch_rult[ch_idx]=1, then advance.
  - Else if i_det[ch_idx]=1 (stuck-high before stimulus): o_ch_rult[ch_idx] stays 0, then advance. No stimulus is applied.
  - Else: o_stim[ch_idx]=1 from the next cycle, cnt=0, go to STIM.
  - "Advance" means: go to DONE if ch_idx=CH_NUM-1, else ch_idx+1 and SEL.
- STIM:
  - cnt increments each cycle.
  - If a detect is qualified while cnt<WIN_CYC: latch a pass flag and go to GAP.
  - If cnt reaches WIN_CYC-1 with no detect: the pass flag stays 0; go to GAP.
  - o_stim is high for exactly (cycles spent in STIM), at most WIN_CYC cycles.
- GAP:
  - o_stim=0 and cnt is cleared on entry. Wait GAP_CYC cycles.
  - On the last GAP cycle: o_ch_rult[ch_idx] = pass flag AND ~i_det[ch_idx]. A detector still high at this point is a stuck fail.
  - Then advance.
- DONE:
  - o_abist_done=1, o_lbist_en=1, o_abist_rult=&o_ch_rult.
  - All three hold while i_bist_en=1.
- Abort: i_bist_en=0 in any state forces FSM=IDLE on the next edge.
  - o_stim, o_abist_done, o_lbist_en, o_abist_rult and cnt clear on that edge.
  - o_ch_rult holds its last value until the next i_bist_en rise.
- i_ch_mask is sampled per channel in SEL. Changes during a run affect only channels not yet reached.
- A detect in the same cycle cnt reaches WIN_CYC-1 counts as a pass.

Optional Feature:
- Macro: ABIST_DGL_EN.
- Defined: in STIM, a detect qualifies only after i_det[ch_idx] has been high for DGL_CYC consecutive cycles.
  - The run counter resets when i_det drops.
  - The qualification must complete before cnt reaches WIN_CYC-1.
- Undefined: a single-cycle high on i_det qualifies; DGL_CYC is ignored and no deglitch logic is instantiated.
- The SEL and GAP stuck checks always use raw i_det.

Test Plan:
All scenarios use CLK_M=4, CH_NUM=4, WIN_US=2 (WIN_CYC=8), GAP_US=1 (GAP_CYC=4), DGL_CYC=3.
- Nominal: bist_en=1, mask=0, each i_det rises 3 cycles after its o_stim and falls when o_stim falls -> o_ch_rult=4'b1111, o_abist_rult=1, done=1 and lbist_en=1 within 40 cycles, o_stim always one-hot or zero.
- No response: ch2 i_det never rises -> o_stim[2] high exactly 8 cycles, o_ch_rult=4'b1011, o_abist_rult=0, o_lbist_en=1.
- Mask: mask=4'b0101 -> o_stim[0] and o_stim[2] never assert, o_ch_rult=4'b1111 with ch1 and ch3 responding.
- Stuck: i_det[1] held high throughout -> o_stim[1] never asserts, o_ch_rult[1]=0. Separately, i_det[3] stays high through GAP -> o_ch_rult[3]=0.
- Abort: drop bist_en on the 2nd STIM cycle of ch1 -> next cycle o_stim=0, done=0, lbist_en=0, o_ch_rult holds 4'b0001. Re-raising bist_en clears o_ch_rult to 0 and restarts from ch0.
- Deglitch: ch0 i_det pulses 2 cycles high -> with ABIST_DGL_EN o_ch_rult[0]=0; without the macro o_ch_rult[0]=1.
